wb_burst_master: RTL

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: takes a command (address, word count,
// direction, byte select), streams write words in or read words out, and
// issues one single classic cycle per word with an optional bus timeout.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// WDATA  | waiting for the next write word on the wr stream
// BUS    | cyc/stb asserted, waiting for ack, err or timeout
// RDOUT  | holding a read word on the rd stream until taken
// FINISH | one-cycle done pulse with status_err
module wb_burst_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int COUNT_WIDTH  = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [COUNT_WIDTH-1:0]  cmd_len,
    input  logic                    cmd_we,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    status_err,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    input  logic                    ack_i,
    input  logic                    err_i
);

    // Timeout counter only needs to reach TIMEOUT-1; abort fires on the
    // TIMEOUT-th BUS cycle without a response.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]          TCNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        BUS    = 3'd2,
        RDOUT  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [TW-1:0]          tcnt;
    logic                   timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TCNT_LAST);

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            tcnt       <= '0;
            cmd_ready  <= 1'b0;
            wr_ready   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status_err <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            we_o       <= 1'b0;
            sel_o      <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
        end else begin
            done       <= 1'b0;
            status_err <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        adr_o     <= cmd_addr;
                        we_o      <= cmd_we;
                        sel_o     <= cmd_sel;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (cmd_we) begin
                            state    <= WDATA;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= BUS;
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            tcnt  <= '0;
                        end
                    end
                end
                WDATA: begin
                    if (wr_valid) begin
                        wr_ready <= 1'b0;
                        dat_o    <= wr_data;
                        state    <= BUS;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        tcnt     <= '0;
                    end
                end
                BUS: begin
                    if (err_i || (!ack_i && timeout_hit)) begin
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        state      <= FINISH;
                        done       <= 1'b1;
                        status_err <= 1'b1;
                    end else if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        adr_o <= adr_o + ADDR_STEP;
                        if (we_o) begin
                            remaining <= remaining - ONE;
                            if (remaining == ONE) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state    <= WDATA;
                                wr_ready <= 1'b1;
                            end
                        end else begin
                            rd_data  <= dat_i;
                            rd_valid <= 1'b1;
                            state    <= RDOUT;
                        end
                    end else if (TIMEOUT != 0) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RDOUT: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= BUS;
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            tcnt  <= '0;
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
